// File: rtl/mips_alu_md_if.sv
// mips_alu_md_if -- request/response bundle for the mips_alu_md block.
//
// Request side (driven by the master):
//   valid_in     : an operation request is present this cycle
//   aluControl   : 4-bit operation code
//   in1, in2     : WIDTH-bit operands
//   shiftAmount  : SHW-bit shift distance
// Response side (driven by the slave, i.e. the ALU):
//   ready        : the ALU can accept a request this cycle
//   aluResult    : registered result
//   zero         : registered zero / compare flag
//   valid_out    : one-cycle pulse marking a completed operation
//   hi, lo       : multiply/divide result registers
//   div_by_zero  : last completed divide had a zero divisor
interface mips_alu_md_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             valid_in;
    logic             ready;
    logic [3:0]       aluControl;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [SHW-1:0]   shiftAmount;
    logic [WIDTH-1:0] aluResult;
    logic             zero;
    logic             valid_out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output valid_in, aluControl, in1, in2, shiftAmount,
        input  ready, aluResult, zero, valid_out, hi, lo, div_by_zero
    );

    modport slave (
        input  valid_in, aluControl, in1, in2, shiftAmount,
        output ready, aluResult, zero, valid_out, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mips_alu_md.sv
// mips_alu_md -- MIPS-style ALU with a sequential multiply/divide unit.
//
// Single-cycle ops (codes 0-13) produce aluResult/zero/valid_out on the
// edge that accepts them. MULTU (14) and DIVU (15) iterate one bit per
// cycle, then publish {hi,lo} with a valid_out pulse WIDTH+1 edges after
// acceptance. ready is high only while the sequencer is idle.
//
// Ports:
//   clk  : clock, rising-edge
//   rst  : asynchronous active-high reset
//   bus  : mips_alu_md_if.slave (request, operands, results, flags)
module mips_alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic           clk,
    input  logic           rst,
    mips_alu_md_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t           state;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             dz_pending;

    logic             accept;
    logic [WIDTH-1:0] single_result;
    logic             single_zero;

    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign accept = bus.valid_in && bus.ready;

    // Combinational result for the single-cycle opcodes.
    always_comb begin
        single_result = '0;
        unique case (bus.aluControl)
            4'd0, 4'd1: single_result = bus.in1 + bus.in2;
            4'd2:       single_result = bus.in1 - bus.in2;
            4'd3:       single_result = bus.in1 & bus.in2;
            4'd4:       single_result = bus.in1 | bus.in2;
            4'd5:       single_result = bus.in1 << bus.shiftAmount;
            4'd6:       single_result = bus.in1 >> bus.shiftAmount;
            4'd7, 4'd8: single_result = bus.in1 - bus.in2;
            4'd9:       single_result = {{(WIDTH-1){1'b0}},
                                         ($signed(bus.in1) < $signed(bus.in2))};
            4'd10:      single_result = $signed(bus.in1) >>> bus.shiftAmount;
            4'd11:      single_result = bus.in1 ^ bus.in2;
            4'd12:      single_result = ~(bus.in1 | bus.in2);
            4'd13:      single_result = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
            default:    single_result = '0;
        endcase
    end

    // BEQ/BNE report the comparison in zero; everything else reports result==0.
    always_comb begin
        single_zero = (single_result == '0);
        if (bus.aluControl == 4'd7) begin
            single_zero = (bus.in1 == bus.in2);
        end else if (bus.aluControl == 4'd8) begin
            single_zero = (bus.in1 != bus.in2);
        end
    end

    // One iteration of shift-add multiply and restoring divide.
    // Multiply: acc_hi:acc_lo holds partial product : remaining multiplier.
    // Divide:   acc_hi:acc_lo holds partial remainder : dividend/quotient.
    // A zero divisor always "fits", so the quotient fills with ones and the
    // remainder ends up equal to the dividend without any special casing.
    always_comb begin
        mul_add   = acc_lo[0] ? opnd : '0;
        mul_sum   = {1'b0, acc_hi} + {1'b0, mul_add};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift[WIDTH] || (div_shift[WIDTH-1:0] >= opnd);
        div_diff  = div_shift[WIDTH-1:0] - opnd;
    end

    // Sequencer and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            opnd            <= '0;
            dz_pending      <= 1'b0;
            bus.ready       <= 1'b1;
            bus.aluResult   <= '0;
            bus.zero        <= 1'b0;
            bus.valid_out   <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        bus.div_by_zero <= 1'b0;
                        if (bus.aluControl == 4'd14) begin
                            state      <= MUL;
                            bus.ready  <= 1'b0;
                            count      <= '0;
                            acc_hi     <= '0;
                            acc_lo     <= bus.in2;
                            opnd       <= bus.in1;
                            dz_pending <= 1'b0;
                        end else if (bus.aluControl == 4'd15) begin
                            state      <= DIV;
                            bus.ready  <= 1'b0;
                            count      <= '0;
                            acc_hi     <= '0;
                            acc_lo     <= bus.in1;
                            opnd       <= bus.in2;
                            dz_pending <= (bus.in2 == '0);
                        end else begin
                            bus.aluResult <= single_result;
                            bus.zero      <= single_zero;
                            bus.valid_out <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    count  <= count + SHW'(1);
                    if (count == SHW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DIV: begin
                    if (div_ge) begin
                        acc_hi <= div_diff;
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + SHW'(1);
                    if (count == SHW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.hi          <= acc_hi;
                    bus.lo          <= acc_lo;
                    bus.aluResult   <= acc_lo;
                    bus.zero        <= (acc_lo == '0);
                    bus.valid_out   <= 1'b1;
                    bus.div_by_zero <= dz_pending;
                    bus.ready       <= 1'b1;
                    count           <= '0;
                    state           <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_md.sv
// tb_mips_alu_md -- directed self-checking bench for mips_alu_md (WIDTH=32).
// Drives requests through the interface, compares every response against
// hand-computed values and prints a single summary line at the end.
module tb_mips_alu_md;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mips_alu_md_if #(.WIDTH(32), .SHW(5)) bus ();

    mips_alu_md #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, observed, expected);
        end
    endtask

    // Present one request and let one rising edge pass; outputs are then
    // sampled 1 unit after that edge. valid_in is left high for chaining.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
        bus.aluControl  = op;
        bus.in1         = a;
        bus.in2         = b;
        bus.shiftAmount = sh;
        bus.valid_in    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idleBus();
        bus.valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Launch a multi-cycle op and count edges until valid_out. A stray
    // request with changed operands is pushed at edge 5 while busy.
    task automatic runMulti(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int edges,
                            output int ready_bad);
        edges     = 0;
        ready_bad = 0;
        applyStimulus(op, a, b, 5'd0);
        bus.valid_in = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) begin
                bus.aluControl = 4'd0;
                bus.in1        = 32'h1234_5678;
                bus.in2        = 32'd3;
                bus.valid_in   = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.valid_in = 1'b0;
            if (bus.valid_out === 1'b1) begin
                edges = k;
                break;
            end
            if (bus.ready !== 1'b0) ready_bad++;
        end
    endtask

    initial begin
        int edges;
        int ready_bad;
        int stray;

        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus.valid_in    = 1'b0;
        bus.aluControl  = 4'd0;
        bus.in1         = '0;
        bus.in2         = '0;
        bus.shiftAmount = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready",  64'(bus.ready),       64'd1);
        checkOutput("reset_valid",  64'(bus.valid_out),   64'd0);
        checkOutput("reset_result", 64'(bus.aluResult),   64'd0);
        checkOutput("reset_zero",   64'(bus.zero),        64'd0);
        checkOutput("reset_hilo",   {bus.hi, bus.lo},     64'd0);
        checkOutput("reset_dbz",    64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // SUB 5-7 wraps; valid_out is a single pulse.
        applyStimulus(4'd2, 32'd5, 32'd7, 5'd0);
        checkOutput("sub_result", 64'(bus.aluResult), 64'hFFFF_FFFE);
        checkOutput("sub_zero",   64'(bus.zero),      64'd0);
        checkOutput("sub_valid",  64'(bus.valid_out), 64'd1);
        idleBus();
        checkOutput("sub_pulse_end", 64'(bus.valid_out), 64'd0);

        // BEQ then BNE back to back.
        applyStimulus(4'd7, 32'd10, 32'd10, 5'd0);
        checkOutput("beq_zero",   64'(bus.zero),      64'd1);
        checkOutput("beq_result", 64'(bus.aluResult), 64'd0);
        checkOutput("beq_valid",  64'(bus.valid_out), 64'd1);
        applyStimulus(4'd8, 32'd10, 32'd10, 5'd0);
        checkOutput("bne_zero",  64'(bus.zero),      64'd0);
        checkOutput("bne_valid", 64'(bus.valid_out), 64'd1);

        // Signed vs unsigned compare.
        applyStimulus(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0);
        checkOutput("slt_result", 64'(bus.aluResult), 64'd1);
        applyStimulus(4'd13, 32'hFFFF_FFFF, 32'd1, 5'd0);
        checkOutput("sltu_result", 64'(bus.aluResult), 64'd0);
        checkOutput("sltu_zero",   64'(bus.zero),      64'd1);

        // Shifts at the maximum distance.
        applyStimulus(4'd10, 32'h8000_0000, 32'd0, 5'd31);
        checkOutput("sra_result", 64'(bus.aluResult), 64'hFFFF_FFFF);
        applyStimulus(4'd6, 32'h8000_0000, 32'd0, 5'd31);
        checkOutput("srl_result", 64'(bus.aluResult), 64'd1);
        applyStimulus(4'd5, 32'd1, 32'd0, 5'd31);
        checkOutput("sll_result", 64'(bus.aluResult), 64'h8000_0000);

        // Logic ops and ADD wrap-around through opcode 1.
        applyStimulus(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        checkOutput("and_result", 64'(bus.aluResult), 64'h0000_F000);
        applyStimulus(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        checkOutput("or_result", 64'(bus.aluResult), 64'h0000_FFF0);
        applyStimulus(4'd11, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        checkOutput("xor_result", 64'(bus.aluResult), 64'h0000_0FF0);
        applyStimulus(4'd12, 32'd0, 32'd0, 5'd0);
        checkOutput("nor_result", 64'(bus.aluResult), 64'hFFFF_FFFF);
        applyStimulus(4'd1, 32'hFFFF_FFFF, 32'd1, 5'd0);
        checkOutput("add_wrap_result", 64'(bus.aluResult), 64'd0);
        checkOutput("add_wrap_zero",   64'(bus.zero),      64'd1);
        checkOutput("single_hilo",     {bus.hi, bus.lo},   64'd0);
        idleBus();

        // MULTU 0xFFFFFFFF x 2 = 0x1_FFFFFFFE.
        runMulti(4'd14, 32'hFFFF_FFFF, 32'd2, edges, ready_bad);
        checkOutput("mul_latency",  64'(edges),         64'd33);
        checkOutput("mul_busy",     64'(ready_bad),     64'd0);
        checkOutput("mul_hi",       64'(bus.hi),        64'd1);
        checkOutput("mul_lo",       64'(bus.lo),        64'hFFFF_FFFE);
        checkOutput("mul_result",   64'(bus.aluResult), 64'hFFFF_FFFE);
        checkOutput("mul_zero",     64'(bus.zero),      64'd0);
        idleBus();
        checkOutput("mul_pulse_end", 64'(bus.valid_out), 64'd0);
        checkOutput("mul_ready",     64'(bus.ready),     64'd1);

        // Single-cycle op must leave hi/lo alone.
        applyStimulus(4'd0, 32'd2, 32'd3, 5'd0);
        checkOutput("add_keeps_hilo", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
        idleBus();

        // DIVU 100/7.
        runMulti(4'd15, 32'd100, 32'd7, edges, ready_bad);
        checkOutput("div_latency", 64'(edges),           64'd33);
        checkOutput("div_busy",    64'(ready_bad),       64'd0);
        checkOutput("div_lo",      64'(bus.lo),          64'd14);
        checkOutput("div_hi",      64'(bus.hi),          64'd2);
        checkOutput("div_dbz",     64'(bus.div_by_zero), 64'd0);
        idleBus();

        // DIVU 9/0, then a following ADD clears the flag.
        runMulti(4'd15, 32'd9, 32'd0, edges, ready_bad);
        checkOutput("div0_latency", 64'(edges),           64'd33);
        checkOutput("div0_lo",      64'(bus.lo),          64'hFFFF_FFFF);
        checkOutput("div0_hi",      64'(bus.hi),          64'd9);
        checkOutput("div0_dbz",     64'(bus.div_by_zero), 64'd1);
        idleBus();
        applyStimulus(4'd0, 32'd2, 32'd3, 5'd0);
        checkOutput("dbz_clear",  64'(bus.div_by_zero), 64'd0);
        checkOutput("dbz_add",    64'(bus.aluResult),   64'd5);
        idleBus();

        // Reset 10 cycles into a MULTU: asynchronous clear, no late pulse.
        applyStimulus(4'd14, 32'd7, 32'd9, 5'd0);
        bus.valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_ready",  64'(bus.ready),       64'd1);
        checkOutput("rst_valid",  64'(bus.valid_out),   64'd0);
        checkOutput("rst_result", 64'(bus.aluResult),   64'd0);
        checkOutput("rst_hilo",   {bus.hi, bus.lo},     64'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out !== 1'b0) stray++;
        end
        checkOutput("rst_no_pulse", 64'(stray),        64'd0);
        checkOutput("rst_hilo_after", {bus.hi, bus.lo}, 64'd0);
        applyStimulus(4'd0, 32'd1, 32'd1, 5'd0);
        checkOutput("rst_add_result", 64'(bus.aluResult), 64'd2);
        checkOutput("rst_add_valid",  64'(bus.valid_out), 64'd1);
        idleBus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
